credit_arbiter: RTL
===================

CREDIT_ARBITER -- requirements
Module: credit_arbiter

Interface
REQ-001 Parameter ID_WIDTH, default 4, SHALL set the request ID width.
REQ-002 Parameter MAX_OUTSTANDING, default 4, SHALL set the maximum number of requests in flight at the shared resource (range 1..15).
REQ-003 Parameter STARVE_LIMIT, default 8, SHALL set the consecutive lost-cycle count that forces a grant (range 1..15).
REQ-004 Ports SHALL be:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset.
- in_valid_1 / in_valid_2  input  1  request pending at pipeline 1 / 2 output.
- in_id_1 / in_id_2  input  ID_WIDTH  ID of pending request 1 / 2.
- in_flush_1 / in_flush_2  input  1  flush strobe for pipeline 1 / 2.
- in_flush_id_1 / in_flush_id_2  input  ID_WIDTH  ID being flushed.
- in_ready  input  1  shared resource accepts a request this cycle.
- in_resp_valid  input  1  shared resource returns one response (frees one credit).
- out_valid  output  1  grant issued this cycle.
- out_choice  output  1  0 = requester 1, 1 = requester 2.
- out_stall_1 / out_stall_2  output  1  hold request 1 / 2.
- out_credits  output  4  free credits.
- out_starve  output  1  current grant is a starvation override.
- out_overflow  output  1  sticky response-without-credit error.

Function
REQ-005 eligible_i SHALL be in_valid_i AND NOT (in_flush_i AND in_flush_id_i == in_id_i).
REQ-006 can_issue SHALL be in_ready AND out_credits != 0.
REQ-007 out_valid SHALL be can_issue AND (eligible_1 OR eligible_2), combinationally, same cycle.
REQ-008 Selection priority: (a) requester with starve_cnt == STARVE_LIMIT and eligible, requester 1 if both; (b) if both eligible, the one not equal to last_grant; (c) the only eligible requester.
REQ-009 When out_valid=0, out_choice SHALL equal last_grant.
REQ-010 out_starve SHALL be 1 only when out_valid=1 and rule REQ-008(a) selected the grant.
REQ-011 out_stall_i SHALL be eligible_i AND NOT (out_valid AND out_choice selects i); a flushed request SHALL never stall.
REQ-012 last_grant register SHALL update to out_choice on each rising edge with out_valid=1; otherwise hold.
REQ-013 Credit counter: grant only -> decrement; in_resp_valid only -> increment; both same cycle -> unchanged.
REQ-014 in_resp_valid with counter == MAX_OUTSTANDING and no grant SHALL leave counter at MAX_OUTSTANDING and set out_overflow, held until reset.
REQ-015 No grant SHALL issue at out_credits == 0, regardless of in_ready or starvation.
REQ-016 starve_cnt_i (4 bits) SHALL increment, saturating at STARVE_LIMIT, each cycle eligible_i=1 and i not granted; SHALL clear when i is granted or eligible_i=0.
REQ-017 Cycles with can_issue=0 SHALL still advance starve counters of eligible requesters.

Reset
REQ-018 While reset=0, asynchronously: credits = MAX_OUTSTANDING, last_grant = 1 (requester 1 wins first tie), starve counters = 0, out_overflow = 0.
REQ-019 During reset, out_valid, out_starve, out_stall_1, out_stall_2 SHALL be 0 and out_choice SHALL be 1.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight credit accounting; responses arriving after reset release SHALL follow REQ-014.

Verification
REQ-021 Both valid, in_ready=1, no responses, defaults -> grants 1,2,1,2 on four cycles, out_credits 3,2,1,0, then out_valid=0 with both stalls=1.
REQ-022 Credits 0, in_resp_valid pulse one cycle with both valid -> next cycle out_credits=1, one grant, out_credits back to 0.
REQ-023 Requester 1 valid, in_flush_1=1 with in_flush_id_1 == in_id_1 -> out_valid=0, out_stall_1=0, credits unchanged.
REQ-024 in_ready=0 for 8 cycles with both valid, then in_ready=1 -> both counters at 8, requester 1 granted with out_starve=1, requester 2 granted next with out_starve=1.
REQ-025 Credits 4, in_resp_valid=1 with no grant -> out_overflow=1, out_credits stays 4; reset=0 -> out_overflow=0.
REQ-026 Grant and in_resp_valid in same cycle at credits 2 -> out_credits remains 2; reset pulse mid-burst -> outputs per REQ-019 immediately, credits 4 after release.

Source files
------------

// File: rtl/credit_arbiter.sv
// Two-requester arbiter for a shared resource with credit-based flow control and starvation override.
// Grant is combinational in the request cycle; credits, last_grant and starve counters update on the clock edge.
module credit_arbiter #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_1,
  input  logic                in_valid_2,
  input  logic [ID_WIDTH-1:0] in_id_1,
  input  logic [ID_WIDTH-1:0] in_id_2,
  input  logic                in_flush_1,
  input  logic                in_flush_2,
  input  logic [ID_WIDTH-1:0] in_flush_id_1,
  input  logic [ID_WIDTH-1:0] in_flush_id_2,
  input  logic                in_ready,
  input  logic                in_resp_valid,
  output logic                out_valid,
  output logic                out_choice,
  output logic                out_stall_1,
  output logic                out_stall_2,
  output logic [3:0]          out_credits,
  output logic                out_starve,
  output logic                out_overflow
);

  localparam logic [3:0] MAX_CREDITS = 4'(MAX_OUTSTANDING);
  localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);

  logic [3:0] credits;
  logic [3:0] starve_cnt_1;
  logic [3:0] starve_cnt_2;
  logic       last_grant;
  logic       overflow;

  logic eligible_1;
  logic eligible_2;
  logic can_issue;
  logic grant;
  logic choice;
  logic starve_sel;
  logic grant_1;
  logic grant_2;

  assign eligible_1 = in_valid_1 && !(in_flush_1 && (in_flush_id_1 == in_id_1));
  assign eligible_2 = in_valid_2 && !(in_flush_2 && (in_flush_id_2 == in_id_2));
  assign can_issue  = in_ready && (credits != 4'd0);
  assign grant      = can_issue && (eligible_1 || eligible_2);

  // Starved requester wins outright (requester 1 first); otherwise alternate on a tie.
  always_comb begin
    choice     = last_grant;
    starve_sel = 1'b0;
    if (eligible_1 && (starve_cnt_1 == STARVE_MAX)) begin
      choice     = 1'b0;
      starve_sel = 1'b1;
    end else if (eligible_2 && (starve_cnt_2 == STARVE_MAX)) begin
      choice     = 1'b1;
      starve_sel = 1'b1;
    end else if (eligible_1 && eligible_2) begin
      choice = ~last_grant;
    end else if (eligible_1) begin
      choice = 1'b0;
    end else if (eligible_2) begin
      choice = 1'b1;
    end
  end

  assign grant_1 = grant && !choice;
  assign grant_2 = grant && choice;

  // Outputs are masked while reset is held so nothing escapes during reset.
  assign out_valid    = reset && grant;
  assign out_choice   = out_valid ? choice : last_grant;
  assign out_starve   = out_valid && starve_sel;
  assign out_stall_1  = reset && eligible_1 && !grant_1;
  assign out_stall_2  = reset && eligible_2 && !grant_2;
  assign out_credits  = credits;
  assign out_overflow = overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits  <= MAX_CREDITS;
      overflow <= 1'b0;
    end else begin
      case ({grant, in_resp_valid})
        2'b10: credits <= credits - 4'd1;
        2'b01: begin
          if (credits == MAX_CREDITS) begin
            overflow <= 1'b1;
          end else begin
            credits <= credits + 4'd1;
          end
        end
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= choice;
    end
  end

  // Lost cycles count even when the resource cannot accept anything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_1 <= 4'd0;
      starve_cnt_2 <= 4'd0;
    end else begin
      if (!eligible_1 || grant_1) begin
        starve_cnt_1 <= 4'd0;
      end else if (starve_cnt_1 != STARVE_MAX) begin
        starve_cnt_1 <= starve_cnt_1 + 4'd1;
      end
      if (!eligible_2 || grant_2) begin
        starve_cnt_2 <= 4'd0;
      end else if (starve_cnt_2 != STARVE_MAX) begin
        starve_cnt_2 <= starve_cnt_2 + 4'd1;
      end
    end
  end

endmodule
